// File: rtl/clk_div_pkg.sv
// Shared definitions for the integer clock divider and its ratio monitor.
package clk_div_pkg;

    // Default width of period/high counters and of the ratio input.
    localparam int CNT_W_DEF = 32;

    // Ratios at or below this value mean the divider is bypassed.
    localparam int RATIO_BYPASS_MAX = 1;

    // Monitor measurement states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_MEAS = 2'd2
    } mon_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with synchronous active-low reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clock_ratio_monitor.sv
// Clock ratio monitor: samples a divided clock in the reference domain,
// measures period and high time, and reports lock / mismatch / stuck.
// Optional duty-cycle checking is enabled by defining
// CLOCK_RATIO_MONITOR_DUTY_CHECK_EN.
// o_valid is a one-cycle pulse with no back-pressure: o_meas_* are
// stable from the o_valid cycle until the next o_valid.
module clock_ratio_monitor
    import clk_div_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int LOCK_COUNT = 4
) (
    input  logic             I_ref_clk,
    input  logic             I_rst_n,
    input  logic             I_mon_clk,
    input  logic             I_mon_en,
    input  logic [CNT_W-1:0] I_expected_ratio,
    output logic [CNT_W-1:0] o_meas_period,
    output logic [CNT_W-1:0] o_meas_high,
    output logic             o_valid,
    output logic             o_lock,
    output logic             o_mismatch,
    output logic             o_stuck
);

    localparam int               MC_W        = $clog2(LOCK_COUNT + 1);
    localparam logic [MC_W-1:0]  LOCK_TARGET = MC_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    mon_state_e       r_state;
    logic [CNT_W-1:0] r_ratio;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [MC_W-1:0]  r_match_cnt;
    logic [CNT_W-1:0] r_meas_period;
    logic [CNT_W-1:0] r_meas_high;
    logic             r_valid;
    logic             r_lock;
    logic             r_mismatch;
    logic             r_stuck;
    logic             r_sync_d;

    logic             w_sync;
    logic             w_rise;
    logic             w_ratio_chg;
    logic             w_cmp_en;
    logic [CNT_W:0]   w_twice_ratio;
    logic             w_over;
    logic             w_duty_ok;
    logic             w_period_ok;
    logic [MC_W-1:0]  w_match_inc;

    sync_2ff u_sync (
        .i_clk   (I_ref_clk),
        .i_rst_n (I_rst_n),
        .i_d     (I_mon_clk),
        .o_q     (w_sync)
    );

    // Delayed copy of the synchronized clock for rising-edge detection.
    always_ff @(posedge I_ref_clk) begin
        if (!I_rst_n) begin
            r_sync_d <= 1'b0;
        end else begin
            r_sync_d <= w_sync;
        end
    end

    assign w_rise        = w_sync & ~r_sync_d;
    assign w_ratio_chg   = (I_expected_ratio != r_ratio);
    assign w_cmp_en      = (r_ratio > CNT_W'(RATIO_BYPASS_MAX));
    assign w_twice_ratio = {r_ratio, 1'b0};
    assign w_over        = ({1'b0, r_cnt} > w_twice_ratio);

`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
    logic [CNT_W-1:0] w_half_lo;
    logic [CNT_W-1:0] w_half_hi;
    // High time must be floor or ceil of half the ratio.
    assign w_half_lo = r_ratio >> 1;
    assign w_half_hi = w_half_lo + {{(CNT_W-1){1'b0}}, r_ratio[0]};
    assign w_duty_ok = (r_hcnt == w_half_lo) || (r_hcnt == w_half_hi);
`else
    assign w_duty_ok = 1'b1;
`endif

    // A saturated counter never counts as a match.
    assign w_period_ok = (r_cnt == r_ratio) && (r_cnt != CNT_MAX) && w_duty_ok;
    assign w_match_inc = (r_match_cnt == LOCK_TARGET) ? r_match_cnt
                                                      : r_match_cnt + 1'b1;

    // Measurement FSM with registered status outputs; disable and ratio
    // change take priority over edge processing.
    always_ff @(posedge I_ref_clk) begin
        if (!I_rst_n) begin
            r_state       <= ST_IDLE;
            r_ratio       <= '0;
            r_cnt         <= '0;
            r_hcnt        <= '0;
            r_match_cnt   <= '0;
            r_meas_period <= '0;
            r_meas_high   <= '0;
            r_valid       <= 1'b0;
            r_lock        <= 1'b0;
            r_mismatch    <= 1'b0;
            r_stuck       <= 1'b0;
        end else begin
            r_ratio    <= I_expected_ratio;
            r_valid    <= 1'b0;
            r_mismatch <= 1'b0;
            if (!I_mon_en) begin
                r_state     <= ST_IDLE;
                r_match_cnt <= '0;
                r_lock      <= 1'b0;
                r_stuck     <= 1'b0;
            end else if (w_ratio_chg) begin
                // Discard the partial period measured against the old ratio.
                r_state     <= ST_ACQ;
                r_match_cnt <= '0;
                r_lock      <= 1'b0;
                r_stuck     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ACQ;
                    end
                    ST_ACQ: begin
                        if (w_rise) begin
                            r_cnt   <= CNT_ONE;
                            r_hcnt  <= CNT_ONE;
                            r_state <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (w_rise) begin
                            r_meas_period <= r_cnt;
                            r_meas_high   <= r_hcnt;
                            r_valid       <= 1'b1;
                            r_cnt         <= CNT_ONE;
                            r_hcnt        <= CNT_ONE;
                            r_stuck       <= 1'b0;
                            if (w_cmp_en) begin
                                if (w_period_ok) begin
                                    r_match_cnt <= w_match_inc;
                                    r_lock      <= (w_match_inc == LOCK_TARGET);
                                end else begin
                                    r_mismatch  <= 1'b1;
                                    r_match_cnt <= '0;
                                    r_lock      <= 1'b0;
                                end
                            end
                        end else begin
                            if (r_cnt != CNT_MAX) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                            if (w_sync && (r_hcnt != CNT_MAX)) begin
                                r_hcnt <= r_hcnt + 1'b1;
                            end
                            if (w_cmp_en && w_over) begin
                                r_stuck <= 1'b1;
                                r_lock  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_meas_period = r_meas_period;
    assign o_meas_high   = r_meas_high;
    assign o_valid       = r_valid;
    assign o_lock        = r_lock;
    assign o_mismatch    = r_mismatch;
    assign o_stuck       = r_stuck;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Self-checking bench for clock_ratio_monitor: table-driven scenarios,
// hand-written corner sequences and randomized runs against a reference
// model built from the sampled input history.
module tb_clock_ratio_monitor;

  localparam int LOCK_N = 4;
  localparam int HN = 65536;

  logic        I_ref_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_mon_clk = 1'b0;
  logic        I_mon_en = 1'b0;
  logic [31:0] I_expected_ratio = 32'd0;
  logic [31:0] o_meas_period;
  logic [31:0] o_meas_high;
  logic        o_valid;
  logic        o_lock;
  logic        o_mismatch;
  logic        o_stuck;

  int errors = 0;
  int checks = 0;

  clock_ratio_monitor #(.CNT_W(32), .LOCK_COUNT(LOCK_N)) dut (
    .I_ref_clk        (I_ref_clk),
    .I_rst_n          (I_rst_n),
    .I_mon_clk        (I_mon_clk),
    .I_mon_en         (I_mon_en),
    .I_expected_ratio (I_expected_ratio),
    .o_meas_period    (o_meas_period),
    .o_meas_high      (o_meas_high),
    .o_valid          (o_valid),
    .o_lock           (o_lock),
    .o_mismatch       (o_mismatch),
    .o_stuck          (o_stuck)
  );

  // ---------------- clock ----------------
  always #5 I_ref_clk = ~I_ref_clk;

  // ---------------- divided-clock generator ----------------
  int g_per = 2;
  int g_high = 1;
  int g_phase = 0;
  bit g_on = 1'b0;

  // ---------------- reference model ----------------
  // hist[n] holds what the monitor sampled at edge n; the synchronized
  // view at edge n is hist[n-2]. Period is the distance between rise
  // edges and high time is a window sum over that history.
  bit          hist [0:HN-1];
  int          cyc = 0;
  int          m_mode = 0;       // 0 idle, 1 waiting first edge, 2 measuring
  int          m_last = 0;
  int          m_matches = 0;
  longint      m_ratio = 0;
  longint      exp_period = 0;
  longint      exp_high = 0;
  bit          exp_valid = 0;
  bit          exp_lock = 0;
  bit          exp_mm = 0;
  bit          exp_stuck = 0;

  function automatic int hidx(input int n);
    return n % HN;
  endfunction

  always @(posedge I_ref_clk) begin : model
    int     n;
    bit     s;
    bit     sp;
    bit     rise;
    bit     ok;
    longint per;
    longint hi;
    n = cyc;
    if (!I_rst_n) begin
      hist[hidx(n)] = 1'b0;
      if (n >= 1) hist[hidx(n-1)] = 1'b0;
      if (n >= 2) hist[hidx(n-2)] = 1'b0;
      m_mode = 0; m_last = 0; m_matches = 0; m_ratio = 0;
      exp_period = 0; exp_high = 0;
      exp_valid = 0; exp_lock = 0; exp_mm = 0; exp_stuck = 0;
    end else begin
      s  = (n >= 2) ? hist[hidx(n-2)] : 1'b0;
      sp = (n >= 3) ? hist[hidx(n-3)] : 1'b0;
      rise = s && !sp;
      hist[hidx(n)] = I_mon_clk;
      exp_valid = 0;
      exp_mm = 0;
      if (!I_mon_en) begin
        m_ratio = longint'(I_expected_ratio);
        m_mode = 0; m_matches = 0; exp_lock = 0; exp_stuck = 0;
      end else if (longint'(I_expected_ratio) != m_ratio) begin
        m_ratio = longint'(I_expected_ratio);
        m_mode = 1; m_matches = 0; exp_lock = 0; exp_stuck = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (rise) begin
          m_last = n;
          m_mode = 2;
        end
      end else begin
        if (rise) begin
          per = longint'(n - m_last);
          hi = 0;
          for (int m = m_last; m < n; m++) hi += longint'(hist[hidx(m-2)]);
          exp_period = per;
          exp_high = hi;
          exp_valid = 1;
          exp_stuck = 0;
          if (m_ratio >= 2) begin
            ok = (per == m_ratio);
`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
            ok = ok && ((hi == m_ratio / 2) || (hi == (m_ratio + 1) / 2));
`endif
            if (ok) begin
              if (m_matches < LOCK_N) m_matches++;
              exp_lock = (m_matches >= LOCK_N);
            end else begin
              exp_mm = 1; m_matches = 0; exp_lock = 0;
            end
          end
          m_last = n;
        end else if (m_ratio >= 2 && longint'(n - m_last) > 2 * m_ratio) begin
          exp_stuck = 1;
          exp_lock = 0;
        end
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  task automatic check_cycle();
    chk("valid", longint'(o_valid), longint'(exp_valid));
    chk("mismatch", longint'(o_mismatch), longint'(exp_mm));
    chk("lock", longint'(o_lock), longint'(exp_lock));
    chk("stuck", longint'(o_stuck), longint'(exp_stuck));
    chk("period", longint'(o_meas_period), exp_period);
    chk("high", longint'(o_meas_high), exp_high);
  endtask

  // One reference cycle: drive generator after the edge, check at negedge.
  task automatic tick();
    @(posedge I_ref_clk);
    #1;
    if (g_on) begin
      I_mon_clk = (g_phase < g_high);
      g_phase = (g_phase + 1) % g_per;
    end else begin
      I_mon_clk = 1'b0;
    end
    @(negedge I_ref_clk);
    check_cycle();
  endtask

  task automatic wait_valid(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (o_valid) seen = 1'b1;
    end
  endtask

  task automatic set_gen(input int per, input int high, input int phase);
    g_per = per; g_high = high; g_phase = phase; g_on = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_period"}, longint'(o_meas_period), 0);
    chk({tag, "_high"}, longint'(o_meas_high), 0);
    chk({tag, "_valid"}, longint'(o_valid), 0);
    chk({tag, "_lock"}, longint'(o_lock), 0);
    chk({tag, "_mm"}, longint'(o_mismatch), 0);
    chk({tag, "_stuck"}, longint'(o_stuck), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int per;
    int high;
    int ratio;
    int cycles;
    int e_period;
    int e_high;
    int e_lock;
  } vec_t;

  vec_t vt [6];

  initial begin
    bit     seen;
    int     nv;
    int     k;
    longint p_hold;
    longint h_hold;

    vt[0] = '{per: 2, high: 1, ratio: 2, cycles: 60, e_period: 2, e_high: 1, e_lock: 1};
    vt[1] = '{per: 5, high: 2, ratio: 5, cycles: 60, e_period: 5, e_high: 2, e_lock: 1};
    vt[2] = '{per: 5, high: 3, ratio: 5, cycles: 60, e_period: 5, e_high: 3, e_lock: 1};
    vt[3] = '{per: 4, high: 2, ratio: 8, cycles: 60, e_period: 4, e_high: 2, e_lock: 0};
    vt[4] = '{per: 3, high: 1, ratio: 3, cycles: 60, e_period: 3, e_high: 1, e_lock: 1};
    vt[5] = '{per: 7, high: 3, ratio: 1, cycles: 60, e_period: 7, e_high: 3, e_lock: 0};

    // Reset state
    I_rst_n = 1'b0; I_mon_en = 1'b1; I_expected_ratio = 32'd2;
    repeat (3) tick();
    check_all_zero("reset");
    I_rst_n = 1'b1;

    // Ratio 2: lock exactly at the fourth o_valid
    set_gen(2, 1, 0);
    nv = 0;
    for (int i = 0; i < 60 && nv < 4; i++) begin
      tick();
      if (o_valid) begin
        nv++;
        if (nv == 3) chk("lock_before_4th", longint'(o_lock), 0);
        if (nv == 4) begin
          chk("lock_at_4th", longint'(o_lock), 1);
          chk("r2_period", longint'(o_meas_period), 2);
          chk("r2_high", longint'(o_meas_high), 1);
        end
      end
    end
    chk("r2_valid_count", longint'(nv), 4);

    // Table-driven scenarios
    for (int v = 0; v < 6; v++) begin
      set_gen(vt[v].per, vt[v].high, 0);
      I_expected_ratio = 32'(vt[v].ratio);
      repeat (vt[v].cycles) tick();
      chk($sformatf("vec%0d_period", v), longint'(o_meas_period), longint'(vt[v].e_period));
      chk($sformatf("vec%0d_high", v), longint'(o_meas_high), longint'(vt[v].e_high));
      chk($sformatf("vec%0d_lock", v), longint'(o_lock), longint'(vt[v].e_lock));
      chk($sformatf("vec%0d_stuck", v), longint'(o_stuck), 0);
    end

    // Ratio change 4 -> 16 while locked
    set_gen(4, 2, 0);
    I_expected_ratio = 32'd4;
    repeat (60) tick();
    chk("r4_locked", longint'(o_lock), 1);
    wait_valid(20, seen);
    chk("r4_valid_seen", longint'(seen), 1);
    set_gen(16, 8, 8);
    I_expected_ratio = 32'd16;
    tick();
    chk("chg_lock_drop", longint'(o_lock), 0);
    wait_valid(100, seen);
    chk("chg_valid_seen", longint'(seen), 1);
    chk("chg_first_period", longint'(o_meas_period), 16);
    chk("chg_first_high", longint'(o_meas_high), 8);

    // Stuck detection: divider held low with ratio 16
    repeat (100) tick();
    chk("r16_locked", longint'(o_lock), 1);
    wait_valid(40, seen);
    chk("r16_valid_seen", longint'(seen), 1);
    g_on = 1'b0;
    k = 0;
    for (int i = 1; i <= 100 && k == 0; i++) begin
      tick();
      if (o_stuck) k = i;
    end
    chk("stuck_delay", longint'(k), 33);
    chk("stuck_lock", longint'(o_lock), 0);
    set_gen(16, 8, 0);
    wait_valid(40, seen);
    chk("unstuck_valid_seen", longint'(seen), 1);
    chk("unstuck_clear", longint'(o_stuck), 0);
    chk("unstuck_mm", longint'(o_mismatch), 1);
    repeat (120) tick();
    chk("relock_after_stuck", longint'(o_lock), 1);

    // Reset in the middle of measurement
    I_rst_n = 1'b0;
    tick();
    check_all_zero("midreset");
    I_rst_n = 1'b1;

    // Enable toggling: outputs hold while idle
    repeat (80) tick();
    chk("pre_idle_period", longint'(o_meas_period), 16);
    p_hold = longint'(o_meas_period);
    h_hold = longint'(o_meas_high);
    I_mon_en = 1'b0;
    repeat (12) begin
      tick();
      chk("idle_valid", longint'(o_valid), 0);
      chk("idle_period_hold", longint'(o_meas_period), p_hold);
      chk("idle_high_hold", longint'(o_meas_high), h_hold);
      chk("idle_lock", longint'(o_lock), 0);
    end
    I_mon_en = 1'b1;
    repeat (120) tick();
    chk("reen_lock", longint'(o_lock), 1);

    // Duty-cycle distortion at ratio 5
    set_gen(5, 2, 0);
    I_expected_ratio = 32'd5;
    repeat (60) tick();
    chk("r5_locked", longint'(o_lock), 1);
    for (int i = 0; i < 10 && g_phase != 4; i++) tick();
    g_high = 4;
`ifdef CLOCK_RATIO_MONITOR_DUTY_CHECK_EN
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (o_mismatch) seen = 1'b1;
    end
    chk("duty_mm_seen", longint'(seen), 1);
    chk("duty_lock_drop", longint'(o_lock), 0);
`else
    repeat (30) tick();
    chk("duty_ignored_lock", longint'(o_lock), 1);
    chk("duty_high_reported", longint'(o_meas_high), 4);
`endif

    // Randomized runs against the model
    for (int r = 0; r < 40; r++) begin
      int per;
      int sel;
      per = int'($urandom_range(2, 12));
      set_gen(per, int'($urandom_range(1, per - 1)), int'($urandom_range(0, per - 1)));
      g_on = ($urandom_range(0, 9) != 0);
      I_mon_en = ($urandom_range(0, 7) != 0);
      sel = int'($urandom_range(0, 5));
      if (sel <= 2) I_expected_ratio = 32'(per);
      else if (sel == 3) I_expected_ratio = 32'(per + 1);
      else if (sel == 4) I_expected_ratio = 32'($urandom_range(0, 1));
      else I_expected_ratio = 32'($urandom_range(0, 14));
      if ($urandom_range(0, 15) == 0) begin
        I_rst_n = 1'b0;
        tick();
        I_rst_n = 1'b1;
      end
      repeat ($urandom_range(20, 80)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
